// File: rtl/linear_deconvolution.sv
// Linear deconvolution: recovers B from kernel A and convolution output C
// (C = A*B) by sequential forward substitution. It does one multiply-accumulate
// per cycle and one exact signed division per recovered sample.
module linear_deconvolution #(
    parameter int size_n = 4,
    parameter int size_m = 4,
    parameter int width  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic signed [width-1:0]   A [size_n],
    input  logic signed [2*width-1:0] C [size_n+size_m-1],
    output logic signed [width-1:0]   B [size_m],
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int aw  = 2*width + $clog2(size_n) + 1;
    localparam int iw  = $clog2((size_n > size_m ? size_n : size_m) + 1);
    localparam int nc  = size_n + size_m - 1;
    localparam int naw = $clog2(size_n);
    localparam int cw  = $clog2(nc);
    localparam int mw  = $clog2(size_m);

    localparam logic [iw-1:0]        lim_max = iw'(size_n - 1);
    localparam logic [iw-1:0]        k_last  = iw'(size_m - 1);
    localparam logic signed [aw-1:0] q_max   = aw'(2**(width-1) - 1);
    localparam logic signed [aw-1:0] q_min   = aw'(-(2**(width-1)));

    typedef enum logic [2:0] {
        st_idle, st_load, st_init, st_mac, st_div, st_done
    } state_t;

    state_t state, state_nxt;

    logic signed [width-1:0]   a_r [size_n];
    logic signed [2*width-1:0] c_r [nc];
    logic signed [aw-1:0]      acc;
    logic [iw-1:0]             j, k, lim;

    logic signed [width-1:0]   a_sel, b_sel;
    logic signed [aw-1:0]      prod, c_ext, a0_ext, q, r;
    logic                      div_bad;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: non-blocking in sequential blocks so every register samples pre-edge values.
        if (!reset) state <= st_idle;
        else        state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        state_nxt = state;
        case (state)
            st_idle: if (start) state_nxt = st_load;
            st_load: state_nxt = (a_r[0] == '0) ? st_done : st_init;
            st_init: state_nxt = (lim != '0) ? st_mac : st_div;
            st_mac:  state_nxt = (j < lim) ? st_mac : st_div;
            st_div:  state_nxt = (div_bad || k == k_last) ? st_done : st_init;
            st_done: state_nxt = st_idle;
            default: state_nxt = st_idle;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state != st_idle) && (state != st_done);
        done = (state == st_done);
    end

    // Datapath operands: term count, MAC product, exact-division test
    always_comb begin
        lim   = (k > lim_max) ? lim_max : k;
        a_sel = a_r[naw'(j)];
        b_sel = B[mw'(k - j)];
        prod  = aw'(a_sel) * aw'(b_sel);
        c_ext = aw'(c_r[cw'(k)]);
        // Divisor forced to 1 when A[0] is zero; that case never reaches DIV.
        a0_ext = aw'(a_r[0]);
        if (a_r[0] == '0) a0_ext = aw'(1);
        q       = acc / a0_ext;
        r       = acc % a0_ext;
        div_bad = (r != '0) || (q > q_max) || (q < q_min);
    end

    // Datapath registers: operand capture, accumulate, divide, error flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the B array is cleared here because its reset value is visible at the port.
            for (int i = 0; i < size_m; i++) B[i] <= '0;
            for (int i = 0; i < size_n; i++) a_r[i] <= '0;
            for (int i = 0; i < nc; i++)     c_r[i] <= '0;
            acc <= '0;
            j   <= '0;
            k   <= '0;
            err <= 1'b0;
        end else begin
            case (state)
                st_idle: begin
                    if (start) begin
                        a_r <= A;
                        c_r <= C;
                        err <= 1'b0;
                    end
                end
                st_load: begin
                    if (a_r[0] == '0) err <= 1'b1;
                    k <= '0;
                end
                st_init: begin
                    acc <= c_ext;
                    j   <= iw'(1);
                end
                st_mac: begin
                    acc <= acc - prod;
                    j   <= j + iw'(1);
                end
                st_div: begin
                    if (div_bad) begin
                        err <= 1'b1;
                    end else begin
                        B[mw'(k)] <= q[width-1:0];
                        if (k != k_last) k <= k + iw'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/linear_deconvolution.md
Name: linear_deconvolution

Overview:
- Inverse of the convolution engine: given kernel A (size_n taps) and convolution output C (size_n+size_m-1 samples), recovers sequence B (size_m samples) such that C = A*B.
- Uses sequential forward substitution: B[k] = (C[k] - sum_{j=1..min(k,size_n-1)} A[j]*B[k-j]) / A[0].
- Performs one multiply-accumulate per cycle and one exact signed division per output sample.
- Sits on the receive side of the convolution datapath and matches its array-port interface and start-driven control.

Parameters:
size_n, 4, number of kernel taps in A
size_m, 4, number of recovered samples in B
width, 8, bit width of A and B elements; C elements are 2*width

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
start  input  1  request; sampled only in IDLE
A  input  size_n x width signed  kernel taps, A[0] is the leading tap
C  input  (size_n+size_m-1) x 2*width signed  convolution samples
B  output  size_m x width signed  recovered sequence (registered)
busy  output  1  high from the cycle after start is accepted until DONE
done  output  1  one-cycle pulse in DONE
err  output  1  sticky error flag for the last run; cleared on next accepted start

Behaviour:
- Reset (reset==0 at a clk edge) forces state IDLE and clears all B[i] to 0, plus busy, done, err and all internal registers. This holds from any state, including mid-operation.
- States are IDLE, LOAD, INIT, MAC, DIV, DONE.
- IDLE -> LOAD when start==1:
  - Capture A and C into internal registers. Later input changes have no effect on the run.
  - Clear err; set busy.
- LOAD:
  - If A[0]==0: set err, go to DONE.
  - Otherwise set k=0 and go to INIT.
- INIT:
  - acc <= sign-extended C[k]; j <= 1.
  - Go to MAC if min(k,size_n-1) >= 1, else go to DIV.
- MAC:
  - acc <= acc - A[j]*B[k-j]; j++.
  - Stay in MAC while j < min(k,size_n-1); then go to DIV.
- DIV:
  - Compute q = acc / A[0] and r = acc % A[0], both signed and truncating.
  - If r != 0 or q lies outside [-2^(width-1), 2^(width-1)-1]: set err, leave B[k] unwritten, go to DONE.
  - Otherwise B[k] <= q[width-1:0].
  - If k == size_m-1, go to DONE; else k++ and go to INIT.
- DONE:
  - done=1 for exactly one cycle; busy=0 in this cycle.
  - Go to IDLE.
- Accumulator width is 2*width + $clog2(size_n) + 1, so no intermediate overflow is possible.
- Latency from the start edge to the done pulse:
  - 1 (LOAD) + sum over k=0..size_m-1 of (2 + min(k,size_n-1)) + 1 (DONE).
  - For the defaults this is 16 cycles.
- start is ignored while busy or in DONE; there is no queuing.
- B holds its values after done until the next accepted run. Each B[k] is overwritten only in its DIV cycle.
- After an error, B[0..k-1] are valid and B[k..] keep their previous values.
- Samples C[size_m..size_n+size_m-2] are captured but not consistency-checked.

Test Plan:
- A={1,1,1,1}, C={1,2,3,4,3,2,1}, start pulse -> done exactly 16 cycles after start edge; B={1,1,1,1}; err=0.
- A={2,1,0,0}, C={2,-1,5,3,0,0,0} -> B={1,-1,3,0}; err=0.
- A={0,1,1,1}, any C -> done 2 cycles after start edge; err=1; B unchanged from prior run.
- A={2,0,0,0}, C={3,0,...} -> err=1 at first DIV; done 4 cycles after start edge; B[0] unchanged. A following run with valid data clears err and produces the correct B.
- A={1,0,0,0}, C[0]=200 (width=8) -> quotient overflow; err=1; B[0] not written.
- Drive reset=0 for one edge mid-MAC -> next cycle state IDLE, B all 0, busy=0, done=0, err=0. A start pulse toggled during busy is ignored and does not change the result.
